// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern player: state encoding, default widths
// and the helper that sizes the length field.
package led_seq_pkg;

  localparam int PAT_W_DEF = 16;
  localparam int REP_W_DEF = 4;
  localparam int PWM_W_DEF = 4;

  // Length needs one bit more than the index so that a full PAT_W pattern fits.
  function automatic int len_width(input int pat_w);
    return $clog2(pat_w) + 1;
  endfunction

  localparam int LEN_W_DEF = len_width(PAT_W_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_PLAY  = 2'd2
  } state_t;

endpackage

// File: rtl/led_pattern_player_if.sv
// Pattern request channel: control logic (master) hands a pattern, length,
// repeat count and brightness to the player (slave) over valid/ready.
interface led_pattern_player_if
  import led_seq_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int REP_W = REP_W_DEF,
  parameter int PWM_W = PWM_W_DEF
);
  localparam int LEN_W = len_width(PAT_W);

  logic             PAT_VALID;
  logic             PAT_READY;
  logic [PAT_W-1:0] PAT_DATA;
  logic [LEN_W-1:0] PAT_LEN;
  logic [REP_W-1:0] PAT_REP;
  logic [PWM_W-1:0] BRIGHT;

  modport master (output PAT_VALID, PAT_DATA, PAT_LEN, PAT_REP, BRIGHT,
                  input  PAT_READY);
  modport slave  (input  PAT_VALID, PAT_DATA, PAT_LEN, PAT_REP, BRIGHT,
                  output PAT_READY);
endinterface

// File: rtl/led_pwm.sv
// Free-running PWM counter and brightness compare; on_phase marks the part of
// each PWM period during which an "on" pattern bit may light the LED.
module led_pwm
  import led_seq_pkg::*;
#(
  parameter int PWM_W = PWM_W_DEF
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [PWM_W-1:0] bright,
  output logic             on_phase
);

  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
    end
  end

  // All-ones must be fully on, which the plain compare alone cannot express.
  assign on_phase = (bright == '1) || (pwm_cnt < bright);

endmodule

// File: rtl/led_pattern_player.sv
// Plays a captured on/off pattern on the LED, one bit per TICK, for a
// programmable number of passes, with PWM dimming of the "on" bits.
module led_pattern_player
  import led_seq_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int REP_W = REP_W_DEF,
  parameter int PWM_W = PWM_W_DEF
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic                 TICK,
  input  logic                 ABORT,
  led_pattern_player_if.slave  pat,
  output logic                 LED,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam int LEN_W = len_width(PAT_W);

  state_t           state, state_nxt;
  logic [PAT_W-1:0] pat_reg;
  logic [LEN_W-1:0] len_reg, len_eff;
  logic [REP_W-1:0] rep_reg, pass_cnt, pass_nxt;
  logic [PWM_W-1:0] bright_reg;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             load, done_nxt, led_nxt, last_bit, more_passes, on_phase;

  led_pwm #(.PWM_W(PWM_W)) u_pwm (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .bright   (bright_reg),
    .on_phase (on_phase)
  );

  // Zero means a full pattern; oversize lengths are clamped so idx stays in range.
  assign len_eff = ((pat.PAT_LEN == '0) || (pat.PAT_LEN > LEN_W'(PAT_W)))
                   ? LEN_W'(PAT_W) : pat.PAT_LEN;

  assign last_bit      = ({1'b0, idx} == (len_reg - LEN_W'(1)));
  assign more_passes   = (rep_reg == '0) || (pass_cnt < rep_reg);
  assign pat.PAT_READY = (state == ST_IDLE);
  assign BUSY          = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    pass_nxt  = pass_cnt;
    done_nxt  = 1'b0;
    load      = 1'b0;
    if (ABORT) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pat.PAT_VALID) begin
            load      = 1'b1;
            state_nxt = ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          if (TICK) begin
            idx_nxt   = '0;
            pass_nxt  = REP_W'(1);
            state_nxt = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (TICK) begin
            if (!last_bit) begin
              idx_nxt = idx + IDX_W'(1);
            end else if (more_passes) begin
              idx_nxt = '0;
              if (rep_reg != '0) begin
                pass_nxt = pass_cnt + REP_W'(1);
              end
            end else begin
              state_nxt = ST_IDLE;
              done_nxt  = 1'b1;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
    // Dark immediately on abort or on the final tick, so LED falls with BUSY.
    led_nxt = (state == ST_PLAY) && (state_nxt == ST_PLAY) && pat_reg[idx] && on_phase;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state      <= ST_IDLE;
      idx        <= '0;
      pass_cnt   <= '0;
      pat_reg    <= '0;
      len_reg    <= '0;
      rep_reg    <= '0;
      bright_reg <= '0;
      LED        <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      pass_cnt <= pass_nxt;
      LED      <= led_nxt;
      DONE     <= done_nxt;
      if (load) begin
        pat_reg    <= pat.PAT_DATA;
        len_reg    <= len_eff;
        rep_reg    <= pat.PAT_REP;
        bright_reg <= pat.BRIGHT;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_player.sv
// Scoreboard bench for led_pattern_player: each finite pattern pushes its
// expected per-tick LED bits; a monitor collects LED per tick and checks on DONE.
module tb_led_pattern_player;
  import led_seq_pkg::*;

  localparam int PAT_W = 16;
  localparam int REP_W = 4;
  localparam int PWM_W = 4;

  logic CLK, RESETN, TICK, ABORT;
  logic LED, BUSY, DONE;

  led_pattern_player_if #(.PAT_W(PAT_W), .REP_W(REP_W), .PWM_W(PWM_W)) pif ();

  led_pattern_player #(.PAT_W(PAT_W), .REP_W(REP_W), .PWM_W(PWM_W)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .TICK   (TICK),
    .ABORT  (ABORT),
    .pat    (pif),
    .LED    (LED),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  typedef struct {
    logic [31:0] bits;
    int          n;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          done_count = 0;
  logic [31:0] obs_bits;
  int          obs_n;
  int          phase;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Divider stand-in: one-cycle TICK every 8 clocks.
  initial begin
    TICK = 1'b0;
    forever begin
      repeat (7) @(posedge CLK);
      #1 TICK = 1'b1;
      @(posedge CLK);
      #1 TICK = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: LED is sampled a few cycles after each tick while busy; DONE closes the record.
  initial begin
    exp_t e;
    obs_bits = '0;
    obs_n    = 0;
    phase    = -1;
    forever begin
      @(negedge CLK);
      if (DONE) begin
        done_count++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_done actual=DONE required=no DONE");
        end else begin
          e = sb.pop_front();
          checkOutput({e.name, "_nbits"}, obs_n, e.n);
          checkOutput({e.name, "_bits"}, obs_bits, e.bits);
        end
        obs_bits = '0;
        obs_n    = 0;
        phase    = -1;
      end else if (!BUSY) begin
        obs_bits = '0;
        obs_n    = 0;
        phase    = -1;
      end else begin
        if (phase >= 0) phase++;
        if (phase == 3) begin
          if (obs_n < 32) obs_bits[obs_n] = LED;
          obs_n++;
          phase = -1;
        end
        if (TICK) phase = 0;
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] data, input logic [4:0] len,
                               input logic [3:0] rep, input logic [3:0] bright,
                               input bit push, input logic [31:0] bits,
                               input int n, input string name);
    exp_t e;
    int   k = 0;
    @(negedge CLK);
    pif.PAT_DATA  = data;
    pif.PAT_LEN   = len;
    pif.PAT_REP   = rep;
    pif.BRIGHT    = bright;
    pif.PAT_VALID = 1'b1;
    while (!pif.PAT_READY && k < 100) begin
      @(negedge CLK);
      k++;
    end
    if (push) begin
      e.bits = bits;
      e.n    = n;
      e.name = name;
      sb.push_back(e);
    end
    @(posedge CLK);
    #1 pif.PAT_VALID = 1'b0;
    checkOutput({name, "_accept_busy"}, BUSY, 1'b1);
    checkOutput({name, "_accept_ready"}, pif.PAT_READY, 1'b0);
  endtask

  task automatic waitDone(input string name, input int budget);
    int k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!DONE && k < budget);
    if (!DONE) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout actual=no DONE after %0d cycles required=DONE", name, budget);
    end
  endtask

  task automatic countLed(input int cycles, output int hi);
    hi = 0;
    repeat (cycles) begin
      @(negedge CLK);
      if (LED) hi++;
    end
  endtask

  initial begin
    int dc;
    int hi;
    int bad;
    int k;
    RESETN        = 1'b0;
    ABORT         = 1'b0;
    pif.PAT_VALID = 1'b0;
    pif.PAT_DATA  = '0;
    pif.PAT_LEN   = '0;
    pif.PAT_REP   = '0;
    pif.BRIGHT    = '0;

    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_led", LED, 1'b0);
    checkOutput("reset_busy", BUSY, 1'b0);
    checkOutput("reset_done", DONE, 1'b0);
    checkOutput("reset_ready", pif.PAT_READY, 1'b1);
    RESETN = 1'b1;

    // Basic playback: bits 1,0,1 once.
    applyStimulus(16'h0005, 5'd3, 4'd1, 4'hF, 1'b1, 32'h0000_0005, 3, "basic");
    waitDone("basic", 200);
    checkOutput("basic_led_at_done", LED, 1'b0);
    checkOutput("basic_ready_at_done", pif.PAT_READY, 1'b1);
    checkOutput("basic_busy_at_done", BUSY, 1'b0);
    @(negedge CLK);
    checkOutput("basic_done_one_cycle", DONE, 1'b0);

    // Length 0 means 16 bits, two passes: high in periods 0, 15, 16, 31.
    dc = done_count;
    applyStimulus(16'h8001, 5'd0, 4'd2, 4'hF, 1'b1, 32'h8001_8001, 32, "rep2");
    waitDone("rep2", 400);
    @(negedge CLK);
    checkOutput("rep2_done_count", done_count - dc, 1);

    // PWM: BRIGHT=4 lights 4 of every 16 cycles; BRIGHT=0 stays dark.
    applyStimulus(16'hFFFF, 5'd16, 4'd0, 4'd4, 1'b0, '0, 0, "pwm4");
    repeat (20) @(negedge CLK);
    countLed(16, hi);
    checkOutput("pwm4_on_cycles", hi, 4);
    @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    applyStimulus(16'hFFFF, 5'd16, 4'd0, 4'd0, 1'b0, '0, 0, "pwm0");
    repeat (20) @(negedge CLK);
    countLed(32, hi);
    checkOutput("pwm0_on_cycles", hi, 0);
    @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;

    // Handshake: VALID held high; the second pattern is accepted right after DONE.
    applyStimulus(16'h0003, 5'd2, 4'd1, 4'hF, 1'b1, 32'h0000_0003, 2, "hsA");
    pif.PAT_DATA  = 16'h0002;
    pif.PAT_LEN   = 5'd2;
    pif.PAT_REP   = 4'd1;
    pif.PAT_VALID = 1'b1;
    begin
      exp_t e;
      e.bits = 32'h0000_0002;
      e.n    = 2;
      e.name = "hsB";
      sb.push_back(e);
    end
    bad = 0;
    k   = 0;
    do begin
      @(negedge CLK);
      k++;
      if (BUSY && pif.PAT_READY) bad++;
    end while (!DONE && k < 200);
    checkOutput("hs_ready_while_busy", bad, 0);
    checkOutput("hsA_done_seen", DONE, 1'b1);
    checkOutput("hsA_ready_at_done", pif.PAT_READY, 1'b1);
    @(negedge CLK);
    checkOutput("hsB_accept_after_done", BUSY, 1'b1);
    pif.PAT_VALID = 1'b0;
    waitDone("hsB", 200);

    // TICK coincident with acceptance must leave the block in ALIGN.
    @(posedge TICK);
    pif.PAT_DATA  = 16'h0001;
    pif.PAT_LEN   = 5'd1;
    pif.PAT_REP   = 4'd1;
    pif.BRIGHT    = 4'hF;
    pif.PAT_VALID = 1'b1;
    begin
      exp_t e;
      e.bits = 32'h0000_0001;
      e.n    = 1;
      e.name = "coinc";
      sb.push_back(e);
    end
    @(posedge CLK);
    #1 pif.PAT_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    checkOutput("coinc_align_busy", BUSY, 1'b1);
    checkOutput("coinc_align_led", LED, 1'b0);
    waitDone("coinc", 100);

    // ABORT on a tick edge with endless repeat: LED dark next cycle, no DONE.
    applyStimulus(16'hFFFF, 5'd16, 4'd0, 4'hF, 1'b0, '0, 0, "abort");
    repeat (3) @(posedge TICK);
    @(negedge CLK);
    checkOutput("abort_pre_led", LED, 1'b1);
    dc    = done_count;
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    checkOutput("abort_led", LED, 1'b0);
    checkOutput("abort_busy", BUSY, 1'b0);
    repeat (40) @(negedge CLK);
    checkOutput("abort_no_done", done_count, dc);

    // Reset mid-PLAY forces outputs without waiting for an edge.
    applyStimulus(16'hFFFF, 5'd16, 4'd0, 4'hF, 1'b0, '0, 0, "rst");
    repeat (2) @(posedge TICK);
    @(negedge CLK);
    checkOutput("rst_pre_led", LED, 1'b1);
    dc = done_count;
    #2 RESETN = 1'b0;
    #1;
    checkOutput("rst_led", LED, 1'b0);
    checkOutput("rst_busy", BUSY, 1'b0);
    checkOutput("rst_done", DONE, 1'b0);
    checkOutput("rst_ready", pif.PAT_READY, 1'b1);
    @(posedge CLK);
    #1 RESETN = 1'b1;
    repeat (20) @(negedge CLK);
    checkOutput("rst_idle_after", BUSY, 1'b0);
    checkOutput("rst_no_done", done_count, dc);
    checkOutput("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
